// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared states and constants for the torpedo game round controller
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        PLAYING,
        WON,
        LOST,
        ARM,
        DRAIN
    } state_t;

    localparam int   START_CYCLES = 2;
    localparam logic KEY_PRESSED  = 1'b0;

endpackage

// File: rtl/game_key_debounce.sv
// rtl/game_key_debounce.sv - key synchronizer, debouncer and one-cycle press pulse
module game_key_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);

    logic                      sync1;
    logic                      sync2;
    logic                      level;
    logic                      level_prev;
    logic [DEBOUNCE_WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= ~KEY_PRESSED;
            sync2      <= ~KEY_PRESSED;
            level      <= ~KEY_PRESSED;
            level_prev <= ~KEY_PRESSED;
            count      <= '0;
            press      <= 1'b0;
        end else begin
            sync1      <= key;
            sync2      <= sync1;
            level_prev <= level;
            press      <= (level == KEY_PRESSED) && (level_prev != KEY_PRESSED);
            // level flips on the 2^DEBOUNCE_WIDTH-th consecutive differing cycle
            if (sync2 != level) begin
                if (&count) begin
                    level <= sync2;
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/game_round_fsm.sv
// rtl/game_round_fsm.sv - round controller: launch, win/loss decision, timer handshake
// Optional hit/miss counters are built only when GAME_SCORE_EN is defined.
module game_round_fsm
    import game_pkg::*;
#(
    parameter int DEBOUNCE_WIDTH = 16,
    parameter int SCORE_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   key,
    input  logic                   strobe_to_restart,
    input  logic                   collision,
    input  logic                   target_within_screen,
    input  logic                   torpedo_within_screen,
    input  logic                   end_of_game_timer_running,
    output logic                   sprite_write,
    output logic                   end_of_game_timer_start,
    output logic                   game_won,
    output logic                   round_active,
    output logic [SCORE_WIDTH-1:0] hits,
    output logic [SCORE_WIDTH-1:0] misses
);

    localparam logic [1:0] START_LAST = 2'(START_CYCLES - 1);

    state_t     state;
    state_t     next;
    logic [1:0] start_cnt;
    logic       press;
    logic       launch;

    game_key_debounce #(
        .DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)
    ) u_key (
        .clk  (clk),
        .reset(reset),
        .key  (key),
        .press(press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            start_cnt <= '0;
        end else begin
            state     <= next;
            start_cnt <= (state == START) ? start_cnt + 1'b1 : 2'd0;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (press || strobe_to_restart) next = START;
            START:   if (start_cnt == START_LAST) next = PLAYING;
            PLAYING: begin
                if (collision)                                         next = WON;
                else if (!target_within_screen || !torpedo_within_screen) next = LOST;
                else if (strobe_to_restart)                            next = LOST;
            end
            WON:     next = ARM;
            LOST:    next = ARM;
            ARM:     if (end_of_game_timer_running) next = DRAIN;
            DRAIN:   if (!end_of_game_timer_running) next = IDLE;
            default: next = IDLE;
        endcase
    end

    assign launch = (state == IDLE) && (next == START);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sprite_write            <= 1'b0;
            end_of_game_timer_start <= 1'b0;
            game_won                <= 1'b0;
            round_active            <= 1'b0;
        end else begin
            sprite_write            <= launch;
            end_of_game_timer_start <= (next == WON) || (next == LOST);
            round_active            <= (next == START) || (next == PLAYING);
            if (next == WON)       game_won <= 1'b1;
            else if (next == LOST) game_won <= 1'b0;
            else if (launch)       game_won <= 1'b0;
        end
    end

`ifdef GAME_SCORE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits   <= '0;
            misses <= '0;
        end else begin
            if (state == PLAYING && next == WON && !(&hits))    hits   <= hits + 1'b1;
            if (state == PLAYING && next == LOST && !(&misses)) misses <= misses + 1'b1;
        end
    end
`else
    assign hits   = '0;
    assign misses = '0;
`endif

endmodule

// File: tb/tb_game_round_fsm.sv
// tb/tb_game_round_fsm.sv - directed self-checking bench for game_round_fsm
module tb_game_round_fsm;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       key;
    logic       strobe_to_restart;
    logic       collision;
    logic       target_within_screen;
    logic       torpedo_within_screen;
    logic       end_of_game_timer_running;
    logic       sprite_write;
    logic       end_of_game_timer_start;
    logic       game_won;
    logic       round_active;
    logic [1:0] hits;
    logic [1:0] misses;

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic seen;

    always #5 clk = ~clk;

    game_round_fsm #(
        .DEBOUNCE_WIDTH(2),
        .SCORE_WIDTH   (2)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .key                      (key),
        .strobe_to_restart        (strobe_to_restart),
        .collision                (collision),
        .target_within_screen     (target_within_screen),
        .torpedo_within_screen    (torpedo_within_screen),
        .end_of_game_timer_running(end_of_game_timer_running),
        .sprite_write             (sprite_write),
        .end_of_game_timer_start  (end_of_game_timer_start),
        .game_won                 (game_won),
        .round_active             (round_active),
        .hits                     (hits),
        .misses                   (misses)
    );

    function automatic int score(input int n);
`ifdef GAME_SCORE_EN
        return (n > 3) ? 3 : n;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input state_t exp);
        check(tag, 32'(dut.state), 32'(exp));
    endtask

    task automatic check_all(input string tag, input logic sw, input logic eots,
                             input logic won, input logic act);
        check({tag, ".sprite_write"}, 32'(sprite_write), 32'(sw));
        check({tag, ".timer_start"}, 32'(end_of_game_timer_start), 32'(eots));
        check({tag, ".game_won"}, 32'(game_won), 32'(won));
        check({tag, ".round_active"}, 32'(round_active), 32'(act));
        check({tag, ".hits"}, 32'(hits), 32'(score(exp_hits)));
        check({tag, ".misses"}, 32'(misses), 32'(score(exp_misses)));
    endtask

    task automatic finish_round(input string tag);
        tick();
        check_state({tag, ".arm"}, ARM);
        check({tag, ".timer_start_drop"}, 32'(end_of_game_timer_start), 32'd0);
        end_of_game_timer_running = 1'b1;
        tick();
        check_state({tag, ".drain"}, DRAIN);
        end_of_game_timer_running = 1'b0;
        tick();
        check_state({tag, ".idle"}, IDLE);
    endtask

    task automatic launch_strobe(input string tag);
        strobe_to_restart = 1'b1;
        tick();
        strobe_to_restart = 1'b0;
        check({tag, ".launch_pulse"}, 32'(sprite_write), 32'd1);
        check({tag, ".launch_clears_won"}, 32'(game_won), 32'd0);
        tick();
        check({tag, ".launch_single"}, 32'(sprite_write), 32'd0);
        tick();
        check_state({tag, ".playing"}, PLAYING);
    endtask

    initial begin
        reset                     = 1'b1;
        key                       = 1'b1;
        strobe_to_restart         = 1'b0;
        collision                 = 1'b0;
        target_within_screen      = 1'b1;
        torpedo_within_screen     = 1'b1;
        end_of_game_timer_running = 1'b0;
        tick();
        tick();
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("reset.state", IDLE);
        reset = 1'b0;
        tick();
        tick();

        // key launch: pulse 2 sync + 4 debounce + 1 press + 1 launch cycles after the fall
        key = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("key.sw%0d", k), 32'(sprite_write), 32'(k == 8));
            if (k == 9) check("key.round_active", 32'(round_active), 32'd1);
            if (k == 10) check_state("key.playing", PLAYING);
        end
        key = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            seen = seen | sprite_write;
        end
        check("key.release_no_launch", 32'(seen), 32'd0);
        check_state("key.still_playing", PLAYING);

        // win by collision
        collision = 1'b1;
        tick();
        collision = 1'b0;
        exp_hits++;
        check_all("win", 1'b0, 1'b1, 1'b1, 1'b0);
        finish_round("win");
        check("win.won_held", 32'(game_won), 32'd1);

        // START ignores collision and off-screen flags
        strobe_to_restart = 1'b1;
        tick();
        strobe_to_restart    = 1'b0;
        check("start.launch", 32'(sprite_write), 32'd1);
        check("start.won_cleared", 32'(game_won), 32'd0);
        collision            = 1'b1;
        target_within_screen = 1'b0;
        tick();
        collision            = 1'b0;
        target_within_screen = 1'b1;
        tick();
        check_state("start.ignored", PLAYING);
        check("start.no_timer", 32'(end_of_game_timer_start), 32'd0);

        // collision together with leaving the screen counts as a win
        collision            = 1'b1;
        target_within_screen = 1'b0;
        tick();
        collision            = 1'b0;
        target_within_screen = 1'b1;
        exp_hits++;
        check_all("simul", 1'b0, 1'b1, 1'b1, 1'b0);
        finish_round("simul");

        // timeout by restart strobe; timer never running keeps ARM
        launch_strobe("timeout");
        strobe_to_restart = 1'b1;
        tick();
        strobe_to_restart = 1'b0;
        exp_misses++;
        check_all("timeout", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        check_state("timeout.arm_wait", ARM);
        end_of_game_timer_running = 1'b1;
        tick();
        end_of_game_timer_running = 1'b0;
        tick();
        check_state("timeout.idle", IDLE);

        // key glitch of 3 cycles is rejected
        key = 1'b0;
        tick();
        tick();
        tick();
        key = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            seen = seen | sprite_write;
        end
        check("glitch.no_launch", 32'(seen), 32'd0);
        check_state("glitch.idle", IDLE);

        // five more wins saturate the 2-bit hit counter
        for (int r = 0; r < 5; r++) begin
            launch_strobe($sformatf("sat%0d", r));
            collision = 1'b1;
            tick();
            collision = 1'b0;
            exp_hits++;
            check($sformatf("sat%0d.hits", r), 32'(hits), 32'(score(exp_hits)));
            finish_round($sformatf("sat%0d", r));
        end
        check_all("sat.final", 1'b0, 1'b0, 1'b1, 1'b0);

        // asynchronous reset mid-round
        launch_strobe("rst");
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        exp_hits   = 0;
        exp_misses = 0;
        check_all("rst.async", 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("rst.state", IDLE);
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen = seen | sprite_write | end_of_game_timer_start;
        end
        check("rst.no_pulse", 32'(seen), 32'd0);
        check_state("rst.idle", IDLE);
        launch_strobe("rst.relaunch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_round_fsm.md
# game_round_fsm

Round controller for the torpedo game: turns a debounced key press or the periodic restart strobe into a one-cycle sprite launch pulse, then watches the collision and on-screen flags to decide each round as won or lost. It drives `game_won` and `end_of_game_timer_start` into the mixer/timer path. It waits for the end-of-game timer to finish before accepting the next launch. It sits between the overlap/sprite stages (upstream) and the timer/mixer (downstream).

## Interface
- `DEBOUNCE_WIDTH`, 16: width of the key debounce counter; the raw key must be stable for 2^DEBOUNCE_WIDTH cycles to be accepted.
- `SCORE_WIDTH`, 8: width of the hit/miss counters.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `key` in 1: raw board button, asynchronous, active-low (0 = pressed).
- `strobe_to_restart` in 1: one-cycle periodic restart strobe.
- `collision` in 1: target/torpedo overlap flag.
- `target_within_screen` in 1: target sprite is on screen.
- `torpedo_within_screen` in 1: torpedo sprite is on screen.
- `end_of_game_timer_running` in 1: end-of-game timer busy.
- `sprite_write` out 1: one-cycle launch pulse to both sprites.
- `end_of_game_timer_start` out 1: one-cycle timer start pulse.
- `game_won` out 1: result of the last decided round.
- `round_active` out 1: high in START and PLAYING.
- `hits` out SCORE_WIDTH: rounds won.
- `misses` out SCORE_WIDTH: rounds lost.

## Operation
- Key path: 2-flop synchronizer → debouncer.
  - The debounced level flips only after the synchronized level has differed from it for 2^DEBOUNCE_WIDTH consecutive cycles.
  - `press` is a one-cycle pulse on the debounced released→pressed transition.
- States:
  - IDLE (reset state): on `press` or `strobe_to_restart`, go to START.
  - START: fixed 2 cycles for sprites to load, then go to PLAYING.
  - PLAYING: see priority rules below.
  - WON, LOST: transient, 1 cycle each, then go to ARM.
  - ARM: wait for `end_of_game_timer_running`=1, then go to DRAIN.
  - DRAIN: wait for `end_of_game_timer_running`=0, then go to IDLE.
- PLAYING priority, highest first:
  1. `collision` → WON.
  2. `target_within_screen`=0 or `torpedo_within_screen`=0 → LOST.
  3. `strobe_to_restart` (timeout) → LOST.
- Simultaneous events:
  - Collision on the same cycle as leaving the screen counts as WON.
  - `press` and `strobe_to_restart` together in IDLE produce one launch.
  - `press` and `strobe_to_restart` outside IDLE are ignored, except for the timeout rule in PLAYING.
- Outputs:
  - `sprite_write` is high for exactly the cycle in which the state is START-first-cycle.
  - `end_of_game_timer_start` is high for the WON/LOST cycle.
  - `game_won` is set to 1 on entering WON and to 0 on entering LOST, and held until the next `sprite_write`, which clears it.
- Counters: `hits` increments in WON and `misses` in LOST; both saturate at all-ones and clear only on reset.
- Reset values:
  - State IDLE.
  - All outputs 0.
  - Debounced key level = released; synchronizer flops = released.
- Reset mid-round: all registers take reset values immediately. Pulse outputs drop asynchronously and no pulse is emitted on reset release.

## Timing
- All outputs are registered.
- Launch latency: `press` or `strobe_to_restart` seen in IDLE in cycle N → `sprite_write`=1 in cycle N+1, PLAYING from N+3.
- Key latency: 2 synchronizer cycles + 2^DEBOUNCE_WIDTH stable cycles + 1 cycle to `press`.
- Decision latency: qualifying input in PLAYING at cycle N → `end_of_game_timer_start`, `game_won` and counter update visible in cycle N+1.
- While in START, the on-screen flags and `collision` are ignored.
- If the timer never asserts running, the FSM stays in ARM; only reset leaves it.

## Configuration
- `GAME_SCORE_EN` defined: `hits`/`misses` counters are built as described.
- Not defined: the counters are not built. `hits` and `misses` are tied to 0, ports remain, and the FSM is unchanged.

## Structure
- Shared package `game_pkg` holds:
  - the state enum (IDLE, START, PLAYING, WON, LOST, ARM, DRAIN);
  - the START length constant (2);
  - the key-pressed polarity constant.
- One sub-module, `game_key_debounce`: synchronizer, debounce counter, `press` pulse output. Parameterized by `DEBOUNCE_WIDTH`, with the same clock/reset.

## Test plan
- Bench uses `DEBOUNCE_WIDTH`=2.
- Launch from key: `key` low for 10 cycles from IDLE → one `sprite_write` pulse exactly 2+4+1+1 cycles after the key falls; `round_active`=1 for the following 2+ cycles.
- Win: in PLAYING, `collision`=1 for one cycle → next cycle `end_of_game_timer_start`=1 for one cycle, `game_won`=1, `hits`=1; timer running 1 then 0 → IDLE.
- Simultaneous: `collision`=1 and `target_within_screen`=0 on the same cycle → WON, `misses` unchanged.
- Timeout/loss: `strobe_to_restart` in PLAYING → LOST, `game_won`=0, `misses`+1. Key glitch shorter than 4 cycles → no `press`.
- Saturation (`GAME_SCORE_EN` defined, `SCORE_WIDTH`=2): 5 wins → `hits`=3. Without the macro: `hits`=`misses`=0 throughout.
- Reset mid-round: assert `reset` in PLAYING → same-cycle state IDLE and all outputs 0; after release, no pulse until a new `press` or strobe.
